// File: rtl/lms_weight_bank.sv
// LMS coefficient store and update engine: each start pass walks every tap, one per cycle,
// through a multiply stage and a write-back stage (LMS, sign-error, leaky or freeze).
module lms_weight_bank #(
  parameter int unsigned N_TAPS     = 32,
  parameter int unsigned DW         = 14,
  parameter int unsigned WW         = 32,
  parameter int unsigned MU_SHIFT   = 5,
  parameter int unsigned LEAK_SHIFT = 8,
  parameter int unsigned WARMUP     = 34
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [DW-1:0]             e_i,
  input  logic [N_TAPS*DW-1:0]      reff_bus_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(N_TAPS)-1:0] wr_addr_i,
  input  logic [WW-1:0]             wr_data_i,
  output logic [N_TAPS*WW-1:0]      weights_bus_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      warm_o
);

  localparam int unsigned IW = $clog2(N_TAPS);
  localparam int unsigned CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [1:0] ModeSign   = 2'b01;
  localparam logic [1:0] ModeLeak   = 2'b10;
  localparam logic [1:0] ModeFreeze = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e                     state_q;
  logic [IW-1:0]              idx_q, s1_idx_q;
  logic                       s1_vld_q;
  logic signed [2*DW-1:0]     prod_q;
  logic signed [DW-1:0]       e_q;
  logic [1:0]                 mode_q;
  logic [N_TAPS-1:0][DW-1:0]  reff_q;
  logic [N_TAPS-1:0][WW-1:0]  w_q;
  logic [CW-1:0]              cnt_q;
  logic                       busy_q, done_q;

  logic                       warm;
  logic                       wr_ok;
  logic                       upd;
  logic signed [DW-1:0]       ref_s1, ref_s2;
  logic signed [2*DW-1:0]     prod_d, prod_sh;
  logic signed [WW-1:0]       w_cur, delta, leak, w_new;
  logic signed [WW:0]         sum;

  assign warm  = (cnt_q == CW'(WARMUP));
  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < (IW + 1)'(N_TAPS));
  assign upd   = s1_vld_q && warm && (mode_q != ModeFreeze);

  assign ref_s1 = reff_q[idx_q];
  assign prod_d = (2*DW)'(e_q) * (2*DW)'(ref_s1);

  // Write-back stage: the sum is one bit wider than a weight so overflow is visible.
  always_comb begin
    w_cur   = w_q[s1_idx_q];
    ref_s2  = reff_q[s1_idx_q];
    prod_sh = prod_q >>> MU_SHIFT;
    delta   = WW'(prod_sh);
    leak    = '0;
    unique case (mode_q)
      ModeSign: begin
        if (e_q == '0)     delta = '0;
        else if (e_q[DW-1]) delta = -WW'(ref_s2);
        else               delta = WW'(ref_s2);
      end
      ModeLeak: leak = w_cur >>> LEAK_SHIFT;
      default: ;
    endcase
    sum = (WW + 1)'(w_cur) + (WW + 1)'(delta) - (WW + 1)'(leak);
    if (sum[WW] != sum[WW-1]) begin
      w_new = sum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    end else begin
      w_new = sum[WW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      s1_idx_q <= '0;
      s1_vld_q <= 1'b0;
      prod_q   <= '0;
      e_q      <= '0;
      mode_q   <= '0;
      reff_q   <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      if (upd) w_q[s1_idx_q] <= w_new;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            e_q     <= e_i;
            mode_q  <= mode_i;
            reff_q  <= reff_bus_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else if (wr_ok) begin
            w_q[wr_addr_i] <= wr_data_i;
          end
        end
        StRun: begin
          prod_q   <= prod_d;
          s1_idx_q <= idx_q;
          s1_vld_q <= 1'b1;
          if (idx_q == IW'(N_TAPS - 1)) state_q <= StDrain;
          else                          idx_q   <= idx_q + IW'(1);
        end
        StDrain: state_q <= StFin;
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!warm) cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign weights_bus_o = w_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign warm_o        = warm;

endmodule

// File: tb/tb_lms_weight_bank.sv
// Self-checking bench for lms_weight_bank: fixed vectors, corner sequences and random passes
// compared with an arithmetic reference model of the coefficient update.
module tb_lms_weight_bank;
  localparam int N = 4, DW = 14, WW = 32, MU = 5, LK = 4, WU = 2;

  typedef int vec_t [N];
  typedef struct {
    string      name;
    int         ev;
    logic [1:0] md;
    vec_t       r;
    vec_t       pre;
    vec_t       ex;
  } tv_s;

  logic            clk = 1'b0;
  logic            rst, start, wr_en;
  logic [1:0]      mode;
  logic [DW-1:0]   e;
  logic [N*DW-1:0] reff;
  logic [1:0]      wr_addr;
  logic [WW-1:0]   wr_data;
  logic [N*WW-1:0] wbus;
  logic            busy, done, warm;

  logic            wr_en2;
  logic [2:0]      wr_addr2;
  logic [WW-1:0]   wr_data2;
  logic [5*WW-1:0] wbus2;
  logic            busy2, done2, warm2;

  int     checks = 0, errors = 0;
  longint mw [N];
  int     mpass;

  lms_weight_bank #(.N_TAPS(N), .DW(DW), .WW(WW), .MU_SHIFT(MU), .LEAK_SHIFT(LK), .WARMUP(WU))
  dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .e_i(e), .reff_bus_i(reff),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .weights_bus_o(wbus),
    .busy_o(busy), .done_o(done), .warm_o(warm)
  );

  // Second instance: 3-bit address can express out-of-range taps; no warm-up hold-off.
  lms_weight_bank #(.N_TAPS(5), .DW(DW), .WW(WW), .MU_SHIFT(MU), .LEAK_SHIFT(LK), .WARMUP(0))
  dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(1'b0), .mode_i(2'b00), .e_i('0), .reff_bus_i('0),
    .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2), .weights_bus_o(wbus2),
    .busy_o(busy2), .done_o(done2), .warm_o(warm2)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint wt(input int i);
    logic signed [WW-1:0] v;
    v = wbus[i*WW +: WW];
    return longint'(v);
  endfunction

  task automatic chk_w(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s w%0d", tag, i), wt(i), mw[i]);
  endtask

  function automatic longint floor_div(input longint p, input int sh);
    longint d, q;
    d = longint'(1) << sh;
    q = p / d;
    if (p < 0 && q * d != p) q = q - 1;
    return q;
  endfunction

  // Reference: new w = clamp(w + delta - floor(w / 2^LK)), applied only once warm.
  task automatic model_pass(input int ev, input logic [1:0] md, input vec_t r);
    longint delta, leak, nv;
    longint lo, hi;
    lo = -(longint'(1) << (WW - 1));
    hi = (longint'(1) << (WW - 1)) - 1;
    if (mpass >= WU && md != 2'b11) begin
      for (int i = 0; i < N; i++) begin
        if (md == 2'b01) delta = (ev > 0) ? longint'(r[i]) : (ev < 0) ? -longint'(r[i]) : 0;
        else             delta = floor_div(longint'(ev) * longint'(r[i]), MU);
        leak = (md == 2'b10) ? floor_div(mw[i], LK) : 0;
        nv = mw[i] + delta - leak;
        if (nv > hi) nv = hi;
        if (nv < lo) nv = lo;
        mw[i] = nv;
      end
    end
    if (mpass < WU) mpass++;
  endtask

  task automatic hw(input int a, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 32'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < N) mw[a] = longint'(d);
  endtask

  task automatic drive(input int ev, input logic [1:0] md, input vec_t r);
    e = DW'(ev); mode = md;
    for (int i = 0; i < N; i++) reff[i*DW +: DW] = DW'(r[i]);
  endtask

  task automatic scramble();
    e = DW'($urandom); mode = 2'($urandom);
    for (int i = 0; i < N; i++) reff[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_pass(input string tag, input int ev, input logic [1:0] md, input vec_t r);
    int n;
    drive(ev, md, r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    scramble();
    chk({tag, " busy"}, longint'(busy), 1);
    n = 0;
    while (!done && n < 4 * N) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " done_lat"}, longint'(n), N + 2);
    chk({tag, " busy_at_done"}, longint'(busy), 0);
    model_pass(ev, md, r);
    chk_w(tag);
    chk({tag, " warm"}, longint'(warm), longint'(mpass == WU));
    @(posedge clk); #1;
    chk({tag, " done_width"}, longint'(done), 0);
  endtask

  initial begin
    tv_s  tv [7];
    vec_t r64, rr;
    int   nd, ev;
    logic [1:0] md;

    tv[0] = '{"floor_a", -100, 2'b00, '{64, 1, -64, 0}, '{0, 0, 0, 0}, '{-200, -4, 200, 0}};
    tv[1] = '{"floor_b", -1, 2'b00, '{1, 0, 0, 0}, '{-200, -4, 200, 0}, '{-201, -4, 200, 0}};
    tv[2] = '{"sat_pos", 8191, 2'b00, '{0, 0, 8191, 0}, '{0, 0, 32'h7FFF_FF00, 0},
              '{0, 0, 32'h7FFF_FFFF, 0}};
    tv[3] = '{"sat_neg", -8192, 2'b00, '{0, 0, 8191, 0}, '{0, 0, 32'h8000_0100, 0},
              '{0, 0, 32'h8000_0000, 0}};
    tv[4] = '{"sign_err", -3, 2'b01, '{10, -20, 0, 5}, '{0, 0, 0, 0}, '{-10, 20, 0, -5}};
    tv[5] = '{"leaky", 0, 2'b10, '{7, -7, 7, 100}, '{1600, 1600, 1600, 1600},
              '{1500, 1500, 1500, 1500}};
    tv[6] = '{"freeze", 500, 2'b11, '{100, 200, -300, 8191}, '{1, 2, 3, 4}, '{1, 2, 3, 4}};
    r64 = '{64, 64, 64, 64};

    rst = 1'b1; start = 1'b0; wr_en = 1'b0; mode = '0; e = '0; reff = '0;
    wr_addr = '0; wr_data = '0; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    mpass = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk_w("reset");
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset warm", longint'(warm), 0);
    chk("reset warm_wu0", longint'(warm2), 1);

    // Host port range on the 5-tap instance.
    wr_en2 = 1'b1; wr_addr2 = 3'd5; wr_data2 = 32'd77;
    @(posedge clk); #1;
    wr_addr2 = 3'd7;
    @(posedge clk); #1;
    chk("wr_oob ignored", longint'(wbus2 == '0), 1);
    wr_addr2 = 3'd4;
    @(posedge clk); #1;
    wr_en2 = 1'b0;
    chk("wr_tap4", longint'(wbus2[4*WW +: WW]), 77);

    do_pass("wu1", 100, 2'b00, r64);
    do_pass("wu2", 100, 2'b00, r64);

    // Third pass: per-edge timing of each tap write and the done pulse.
    drive(100, 2'b00, r64);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    for (int k = 1; k <= N + 2; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        chk($sformatf("edge%0d w%0d", k, i), wt(i), (k >= i + 2) ? 200 : 0);
      chk($sformatf("edge%0d done", k), longint'(done), longint'(k == N + 2));
      chk($sformatf("edge%0d busy", k), longint'(busy), longint'(k < N + 2));
    end
    model_pass(100, 2'b00, r64);
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < N; i++) hw(i, tv[t].pre[i]);
      do_pass(tv[t].name, tv[t].ev, tv[t].md, tv[t].r);
      for (int i = 0; i < N; i++)
        chk($sformatf("%s exp w%0d", tv[t].name, i), wt(i), longint'(tv[t].ex[i]));
    end

    // start and host write while busy are both dropped.
    rr = '{32, 32, 32, 32};
    drive(40, 2'b00, rr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'd12345; e = DW'(1000);
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      if (done) nd++;
    end
    model_pass(40, 2'b00, rr);
    chk("busy_start done_count", longint'(nd), 1);
    chk_w("busy_start");

    // Host write coinciding with start is dropped; the pass still runs.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'd999;
    do_pass("wr_with_start", 7, 2'b11, rr);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < N; i++) hw(i, int'($urandom));
      ev = int'($urandom_range(0, 16383)) - 8192;
      for (int i = 0; i < N; i++) rr[i] = int'($urandom_range(0, 16383)) - 8192;
      md = 2'($urandom);
      do_pass($sformatf("rnd%0d", t), ev, md, rr);
    end

    // Reset at edge 3 of a pass.
    for (int i = 0; i < N; i++) hw(i, 5000 + i);
    drive(300, 2'b00, r64);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    mpass = 0;
    chk_w("midrst");
    chk("midrst busy", longint'(busy), 0);
    chk("midrst warm", longint'(warm), 0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst no_done", longint'(nd), 0);
    do_pass("post_rst", 100, 2'b00, r64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
